// File: rtl/rom_fetch_unit.sv
// -----------------------------------------------------------------------------
// rom_fetch_unit
//
// Instruction fetch unit that sits directly in front of the ROM controller.
// It owns the fetch PC, drives it onto HADDR, captures the word returned on
// HRDATA in the same cycle, and queues {pc, data} pairs in a small prefetch
// FIFO. Decode takes entries from the FIFO head through a valid/ready
// handshake.
//
// Ports:
//   CLK             in   system clock, rising edge
//   RST             in   synchronous active-high reset
//   HADDR           out  byte address to the ROM controller (always fetch_pc)
//   HRDATA          in   ROM read data for HADDR, valid in the same cycle
//   redirect_valid  in   flush the FIFO and restart fetch at redirect_pc
//   redirect_pc     in   new fetch target
//   inst_valid      out  FIFO head holds an instruction
//   inst_data       out  instruction word at the FIFO head (0 when empty)
//   inst_pc         out  byte address of inst_data (0 when empty)
//   inst_ready      in   decode accepts the head this cycle
//   fetch_fault     out  misaligned redirect fault (only with the macro below)
//
// Build option:
//   ROM_FETCH_ALIGN_CHECK_EN  when defined, a redirect to a non word-aligned
//                             address enters a FAULT state and raises
//                             fetch_fault; otherwise the low two address bits
//                             of redirect_pc are dropped on load.
// -----------------------------------------------------------------------------
module rom_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] ROM_START  = 32'h0,
    parameter int unsigned ROM_SIZE   = 20*1024,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] HADDR,
    input  logic [31:0] HRDATA,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef ROM_FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] FULL         = CW'(FIFO_DEPTH);
    // Largest legal offset of fetch_pc from ROM_START (last word of the window).
    localparam logic [31:0]   LAST_OFFSET  = 32'(ROM_SIZE) - 32'd4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
`ifdef ROM_FETCH_ALIGN_CHECK_EN
    localparam logic [1:0] ST_FAULT = 2'd2;
`endif

    // Control state
    logic [1:0]    state_q,    state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0] count_q,    count_d;

    // FIFO storage (data path, not reset; validity is tracked by count_q)
    logic [31:0] pc_mem   [FIFO_DEPTH];
    logic [31:0] data_mem [FIFO_DEPTH];

    logic        deq;
    logic        fetch_go;
    logic        in_window;
    logic [31:0] pc_offset;
    logic [31:0] redirect_target;
    logic [1:0]  redirect_state;

    // Offset-based window test: an address below ROM_START wraps to a large
    // offset, so a single unsigned compare covers both ends of the window.
    assign pc_offset = fetch_pc_q - ROM_START;
    assign in_window = (pc_offset <= LAST_OFFSET);

    assign deq      = (count_q != '0) && inst_ready;
    assign fetch_go = (state_q == ST_RUN) && !redirect_valid && in_window &&
                      ((count_q != FULL) || deq);

`ifdef ROM_FETCH_ALIGN_CHECK_EN
    // Misaligned targets are loaded as-is so the faulting address is visible.
    assign redirect_target = redirect_pc;
    assign redirect_state  = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
    assign fetch_fault     = (state_q == ST_FAULT);
`else
    assign redirect_target = redirect_pc & ~32'h3;
    assign redirect_state  = ST_RUN;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            // Redirect overrides any same-cycle enqueue or dequeue.
            state_d    = redirect_state;
            fetch_pc_d = redirect_target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if ((state_q == ST_RUN) && !in_window) begin
                state_d = ST_HALT;
            end
            if (fetch_go) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({fetch_go, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (fetch_go) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            data_mem[wr_ptr_q] <= HRDATA;
        end
    end

    assign HADDR      = fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst_data  = inst_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q]   : 32'h0;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for rom_fetch_unit: directed scenarios with literal expectations,
// followed by randomized traffic checked every cycle against a queue-based
// reference model of the fetch unit.
// -----------------------------------------------------------------------------
module tb_rom_fetch_unit;

    localparam logic [31:0] WIN_LAST = 32'h0000_4FFC; // last word of 20 KiB ROM at 0
    localparam int          DEPTH    = 4;

    logic        CLK;
    logic        RST;
    logic [31:0] HADDR;
    logic [31:0] HRDATA;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef ROM_FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Reference model state
    logic [31:0] mq_pc[$];
    logic [31:0] mq_dat[$];
    logic [31:0] m_pc    = 32'h0;
    bit          m_halt  = 0;
    bit          m_fault = 0;

    rom_fetch_unit #(
        .RESET_PC   (32'h0),
        .ROM_START  (32'h0),
        .ROM_SIZE   (20*1024),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .HADDR          (HADDR),
        .HRDATA         (HRDATA),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef ROM_FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    // ROM model: every word holds its own byte address.
    assign HRDATA = HADDR;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each rising edge from the sampled inputs.
    initial begin
        bit do_deq;
        bit do_enq;
        forever begin
            @(posedge CLK);
            if (RST) begin
                mq_pc.delete(); mq_dat.delete();
                m_pc = 32'h0; m_halt = 0; m_fault = 0;
            end else if (redirect_valid) begin
                mq_pc.delete(); mq_dat.delete();
                m_halt = 0;
`ifdef ROM_FETCH_ALIGN_CHECK_EN
                m_pc    = redirect_pc;
                m_fault = (redirect_pc % 4) != 0;
`else
                m_pc    = redirect_pc - (redirect_pc % 4);
                m_fault = 0;
`endif
            end else begin
                do_deq = (mq_pc.size() > 0) && inst_ready;
                do_enq = 0;
                if (!m_halt && !m_fault) begin
                    if (m_pc > WIN_LAST) m_halt = 1;
                    else if (mq_pc.size() < DEPTH || do_deq) do_enq = 1;
                end
                if (do_deq) begin
                    void'(mq_pc.pop_front());
                    void'(mq_dat.pop_front());
                end
                if (do_enq) begin
                    mq_pc.push_back(m_pc);
                    mq_dat.push_back(m_pc);   // ROM word equals its address
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                check("m_haddr", HADDR, m_pc);
                check("m_valid", {31'b0, inst_valid}, {31'b0, mq_pc.size() > 0});
                check("m_pc",    inst_pc,   (mq_pc.size() > 0) ? mq_pc[0]  : 32'h0);
                check("m_data",  inst_data, (mq_dat.size() > 0) ? mq_dat[0] : 32'h0);
`ifdef ROM_FETCH_ALIGN_CHECK_EN
                check("m_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
`endif
            end
        end
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    // Directed scenarios and random traffic; inputs change on falling edges.
    initial begin
        int kind;
        RST = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
        cyc(); chk_en = 1;
        cyc(); cyc();
        check("rst_haddr", HADDR, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_data",  inst_data, 32'h0);
        check("rst_pc",    inst_pc,   32'h0);
        RST = 1'b0;

        // Sequential fetch
        cyc();
        check("seq0_valid", {31'b0, inst_valid}, 32'h1);
        check("seq0_pc", inst_pc, 32'h0);
        check("seq0_haddr", HADDR, 32'h4);
        cyc();
        check("seq1_pc", inst_pc, 32'h4);
        check("seq1_data", inst_data, 32'h4);

        // Backpressure from a clean start at 0
        redirect_valid = 1'b1; redirect_pc = 32'h0; inst_ready = 1'b0;
        cyc();
        check("bp_flush_valid", {31'b0, inst_valid}, 32'h0);
        redirect_valid = 1'b0;
        repeat (10) cyc();
        check("bp_haddr_hold", HADDR, 32'h10);
        check("bp_head", inst_pc, 32'h0);
        inst_ready = 1'b1;   // dequeue while full
        cyc();
        check("fulldq_head", inst_pc, 32'h4);
        check("fulldq_haddr", HADDR, 32'h14);
        cyc();
        check("drain_pc8", inst_pc, 32'h8);
        cyc();
        check("drain_pc12", inst_pc, 32'hC);

        // Redirect mid-stream
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc();
        check("rd_valid0", {31'b0, inst_valid}, 32'h0);
        check("rd_haddr", HADDR, 32'h100);
        redirect_valid = 1'b0;
        cyc();
        check("rd_first", inst_pc, 32'h100);
        cyc();
        check("rd_second", inst_pc, 32'h104);

        // End of window
        redirect_valid = 1'b1; redirect_pc = 32'h4FF8;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        check("eow_a", inst_pc, 32'h4FF8);
        cyc();
        check("eow_b", inst_pc, 32'h4FFC);
        check("eow_haddr", HADDR, 32'h5000);
        cyc();
        check("eow_halt_valid", {31'b0, inst_valid}, 32'h0);
        repeat (3) cyc();
        check("eow_halt_haddr", HADDR, 32'h5000);
        check("eow_halt_valid2", {31'b0, inst_valid}, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        check("eow_resume", inst_pc, 32'h0);
        check("eow_resume_v", {31'b0, inst_valid}, 32'h1);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        cyc();
        redirect_valid = 1'b0;
`ifdef ROM_FETCH_ALIGN_CHECK_EN
        check("mis_fault", {31'b0, fetch_fault}, 32'h1);
        check("mis_haddr", HADDR, 32'h102);
        repeat (3) cyc();
        check("mis_fault_hold", {31'b0, fetch_fault}, 32'h1);
        check("mis_novalid", {31'b0, inst_valid}, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc();
        redirect_valid = 1'b0;
        check("mis_clear", {31'b0, fetch_fault}, 32'h0);
        cyc();
        check("mis_resume", inst_pc, 32'h200);
`else
        check("mis_haddr", HADDR, 32'h100);
        cyc();
        check("mis_resume", inst_pc, 32'h100);
`endif

        // Reset wins over a concurrent redirect
        RST = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        cyc();
        check("rstmid_haddr", HADDR, 32'h0);
        check("rstmid_valid", {31'b0, inst_valid}, 32'h0);
        RST = 1'b0; redirect_valid = 1'b0;

        // Random traffic; the ready probability varies between blocks
        for (int blk = 0; blk < 6; blk++) begin
            for (int c = 0; c < 500; c++) begin
                inst_ready     = ($urandom_range(0, 9) < (2 + blk));
                redirect_valid = ($urandom_range(0, 39) == 0);
                kind = $urandom_range(0, 4);
                case (kind)
                    0: redirect_pc = 32'h4FE0 + (32'($urandom_range(0, 7)) << 2);
                    1: redirect_pc = 32'($urandom_range(0, 32'h13FF)) << 2;
                    2: redirect_pc = 32'h100 + 32'($urandom_range(1, 3));
                    3: redirect_pc = 32'h6000 + (32'($urandom_range(0, 3)) << 2);
                    default: redirect_pc = 32'hFFFF_FFF8 + (32'($urandom_range(0, 1)) << 2);
                endcase
                RST = ($urandom_range(0, 399) == 0);
                cyc();
            end
        end
        RST = 1'b0; redirect_valid = 1'b0;

        @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
